// File: rtl/lbm_pkg.sv
// Shared LBM definitions: lane map for the nine distribution RAMs and the
// stream controller state encoding, common to the read and write controllers.
package lbm_pkg;

  localparam int LANES  = 9;
  localparam int LANE_W = 16;

  localparam int L_NULL = 0;
  localparam int L_N    = 1;
  localparam int L_NE   = 2;
  localparam int L_E    = 3;
  localparam int L_SE   = 4;
  localparam int L_S    = 5;
  localparam int L_SW   = 6;
  localparam int L_W    = 7;
  localparam int L_NW   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/bram_stream_writer_addr_counter.sv
// Frame cell counter: cleared on arm, bumped on each written beat; latches the
// pre-increment value as the RAM write address and flags the last cell.
module frame_addr_counter #(
  parameter int DEPTH         = 2500,
  parameter int ADDRESS_WIDTH = 12
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic                     inc_i,
  output logic                     at_last_o,
  output logic [ADDRESS_WIDTH-1:0] wr_addr_o,
  output logic [ADDRESS_WIDTH-1:0] beat_count_o
);

  logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;

  always_comb begin
    cnt_d  = cnt_q;
    addr_d = addr_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      addr_d = cnt_q;
      cnt_d  = cnt_q + ADDRESS_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      addr_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
    end
  end

  // The count only ever reaches DEPTH (one past the last cell), so it doubles as beat_count.
  assign at_last_o    = (cnt_q == ADDRESS_WIDTH'(DEPTH - 1));
  assign wr_addr_o    = addr_q;
  assign beat_count_o = cnt_q;

endmodule

// File: rtl/bram_stream_writer.sv
// AXI-Stream slave that loads one lattice frame of nine-lane distribution
// beats into the distribution RAMs at sequential cell addresses.
module bram_stream_writer
  import lbm_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int DEPTH         = 2500,
  parameter int ADDRESS_WIDTH = 12
) (
  input  logic                          s00_axis_aclk,
  input  logic                          s00_axis_areset,
  input  logic                          frame_arm,
  input  logic                          s00_axis_tvalid,
  output logic                          s00_axis_tready,
  input  logic [LANES*DATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [LANES*DATA_WIDTH/8-1:0] s00_axis_tstrb,
  input  logic                          s00_axis_tlast,
  output logic [ADDRESS_WIDTH-1:0]      wr_addr,
  output logic [LANES-1:0]              wr_en,
  output logic [LANES*DATA_WIDTH-1:0]   wr_data,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          frame_error,
  output logic [ADDRESS_WIDTH-1:0]      beat_count
);

  localparam int BYTES_PER_LANE = DATA_WIDTH / 8;

  state_t                        state_q, state_d;
  logic                          tready_q, tready_d;
  logic                          busy_q, busy_d;
  logic [LANES-1:0]              wr_en_q, wr_en_d;
  logic [LANES*DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                          done_q, done_d;
  logic                          error_q, error_d;

  logic                          handshake;
  logic                          cnt_clr, cnt_inc;
  logic                          at_last;
  logic [LANES-1:0]              lane_mask;

  assign handshake = s00_axis_tvalid & tready_q;

  // A lane is written only when every byte of it is strobed.
  always_comb begin
    lane_mask = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_mask[k] = &s00_axis_tstrb[k*BYTES_PER_LANE +: BYTES_PER_LANE];
    end
  end

  frame_addr_counter #(
    .DEPTH        (DEPTH),
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_counter (
    .clk_i       (s00_axis_aclk),
    .rst_i       (s00_axis_areset),
    .clr_i       (cnt_clr),
    .inc_i       (cnt_inc),
    .at_last_o   (at_last),
    .wr_addr_o   (wr_addr),
    .beat_count_o(beat_count)
  );

  always_comb begin
    state_d   = state_q;
    wr_en_d   = '0;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (frame_arm) begin
          state_d = RECV;
          cnt_clr = 1'b1;
        end
      end
      RECV: begin
        if (handshake) begin
          cnt_inc   = 1'b1;
          wr_en_d   = lane_mask;
          wr_data_d = s00_axis_tdata;
          // Leaving RECV at the last cell guarantees no write at or beyond DEPTH.
          if (s00_axis_tlast) begin
            state_d = IDLE;
            if (at_last) done_d  = 1'b1;
            else         error_d = 1'b1;
          end else if (at_last) begin
            state_d = DRAIN;
            error_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (handshake && s00_axis_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    tready_d = (state_d != IDLE);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      state_q   <= IDLE;
      tready_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_en_q   <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tready_q  <= tready_d;
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign s00_axis_tready = tready_q;
  assign busy            = busy_q;
  assign wr_en           = wr_en_q;
  assign wr_data         = wr_data_q;
  assign frame_done      = done_q;
  assign frame_error     = error_q;

endmodule

// File: tb/tb_bram_stream_writer.sv
// Scoreboard bench for bram_stream_writer: a behavioural frame model predicts
// each RAM write and the done/error pulses, a monitor compares DUT writes.
module tb_bram_stream_writer;
  import lbm_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 12;
  localparam int DW    = 16;

  typedef struct {
    logic [AW-1:0]    addr;
    logic [8:0]       en;
    logic [9*DW-1:0]  data;
  } expWrite_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             frameArm = 1'b0;
  logic             tValid = 1'b0;
  logic             tReady;
  logic [9*DW-1:0]  tData = '0;
  logic [9*DW/8-1:0] tStrb = '0;
  logic             tLast = 1'b0;
  logic [AW-1:0]    wrAddr;
  logic [8:0]       wrEn;
  logic [9*DW-1:0]  wrData;
  logic             busy;
  logic             frameDone;
  logic             frameError;
  logic [AW-1:0]    beatCount;

  int vectorCount = 0;
  int missCount   = 0;

  expWrite_t sb[$];
  state_t    modelState = IDLE;
  int        modelCnt   = 0;
  int        expDone    = 0;
  int        expErr     = 0;
  int        seenDone   = 0;
  int        seenErr    = 0;

  always #5 clk = ~clk;

  bram_stream_writer #(
    .DATA_WIDTH   (DW),
    .DEPTH        (DEPTH),
    .ADDRESS_WIDTH(AW)
  ) dut (
    .s00_axis_aclk  (clk),
    .s00_axis_areset(rst),
    .frame_arm      (frameArm),
    .s00_axis_tvalid(tValid),
    .s00_axis_tready(tReady),
    .s00_axis_tdata (tData),
    .s00_axis_tstrb (tStrb),
    .s00_axis_tlast (tLast),
    .wr_addr        (wrAddr),
    .wr_en          (wrEn),
    .wr_data        (wrData),
    .busy           (busy),
    .frame_done     (frameDone),
    .frame_error    (frameError),
    .beat_count     (beatCount)
  );

  task automatic checkOutput(input string tag, input logic [191:0] observed, input logic [191:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Frame model: decides from its own cell count what the DUT must write.
  task automatic modelBeat(input logic [9*DW-1:0] data, input logic [9*DW/8-1:0] strb, input logic last);
    expWrite_t e;
    if (modelState == RECV) begin
      e.addr = AW'(modelCnt);
      for (int k = 0; k < 9; k++) e.en[k] = strb[2*k] & strb[2*k+1];
      e.data = data;
      sb.push_back(e);
      if (last) begin
        if (modelCnt == DEPTH - 1) expDone++;
        else                       expErr++;
        modelState = IDLE;
      end else if (modelCnt == DEPTH - 1) begin
        expErr++;
        modelState = DRAIN;
      end
      modelCnt++;
    end else if (modelState == DRAIN && last) begin
      modelState = IDLE;
    end
  endtask

  task automatic sendBeat(input logic [9*DW-1:0] data, input logic [9*DW/8-1:0] strb, input logic last);
    bit accepted;
    accepted = 1'b0;
    tData  = data;
    tStrb  = strb;
    tLast  = last;
    tValid = 1'b1;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      accepted = tReady;
      @(posedge clk);
      #1;
    end
    tValid = 1'b0;
    tLast  = 1'b0;
    if (!accepted) checkOutput("tready timeout", 0, 1);
    else           modelBeat(data, strb, last);
  endtask

  task automatic armFrame();
    @(posedge clk);
    #1 frameArm = 1'b1;
    @(posedge clk);
    #1 frameArm = 1'b0;
    modelState = RECV;
    modelCnt   = 0;
  endtask

  // Drives nBeats beats; lastBeat < 0 means no tlast, partialBeat masks lane 1.
  task automatic applyStimulus(input int nBeats, input int lastBeat, input bit gaps, input int partialBeat);
    logic [9*DW-1:0]   data;
    logic [9*DW/8-1:0] strb;
    armFrame();
    for (int b = 0; b < nBeats; b++) begin
      for (int k = 0; k < 9; k++) data[16*k +: 16] = {12'(b), 4'(k)};
      strb = (b == partialBeat) ? 18'h3FFF3 : 18'h3FFFF;
      sendBeat(data, strb, b == lastBeat);
      if (gaps) repeat (2) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic endOfFrame(input string name);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput({name, " busy"}, busy, 0);
    checkOutput({name, " tready"}, tReady, 0);
    checkOutput({name, " beat_count"}, beatCount, AW'(modelCnt));
    checkOutput({name, " done pulses"}, seenDone, expDone);
    checkOutput({name, " error pulses"}, seenErr, expErr);
    checkOutput({name, " pending writes"}, sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (wrEn != 9'd0) begin
        if (sb.size() == 0) begin
          checkOutput("spurious write", {wrAddr, wrEn}, 0);
        end else begin
          expWrite_t e;
          e = sb.pop_front();
          checkOutput("wr_addr", wrAddr, e.addr);
          checkOutput("wr_en", wrEn, e.en);
          checkOutput("wr_data", wrData, e.data);
        end
      end
      if (frameDone) begin
        seenDone++;
        checkOutput("done with last write", {wrEn != 9'd0, wrAddr}, {1'b1, AW'(DEPTH - 1)});
      end
      if (frameError) begin
        seenErr++;
        checkOutput("error with write", wrEn != 9'd0, 1);
      end
    end
  end

  initial begin
    #12;
    checkOutput("reset tready", tReady, 0);
    checkOutput("reset outputs", {wrEn, wrAddr, busy, frameDone, frameError, beatCount}, 0);
    checkOutput("reset wr_data", wrData, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] nominal frame");
    applyStimulus(16, 15, 1'b0, -1);
    endOfFrame("nominal");

    $display("[TB] backpressure gaps");
    applyStimulus(16, 15, 1'b1, -1);
    endOfFrame("gaps");

    $display("[TB] short frame");
    applyStimulus(10, 9, 1'b0, -1);
    endOfFrame("short");

    $display("[TB] long frame");
    applyStimulus(20, 19, 1'b0, -1);
    endOfFrame("long");

    $display("[TB] partial strobe");
    applyStimulus(16, 15, 1'b0, 3);
    endOfFrame("partial");

    $display("[TB] reset mid-frame");
    applyStimulus(8, -1, 1'b0, -1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("midreset outputs", {wrEn, wrAddr, busy, tReady, frameDone, frameError, beatCount}, 0);
    checkOutput("midreset wr_data", wrData, 0);
    checkOutput("midreset pending writes", sb.size(), 0);
    sb.delete();
    modelState = IDLE;
    modelCnt   = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("midreset pulses", {seenDone, seenErr}, {expDone, expErr});

    applyStimulus(16, 15, 1'b0, -1);
    endOfFrame("restart");

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
